// File: rtl/mult_seq_cla.sv
// mult_seq_cla: iterative shift-add multiplier (one conditional add per cycle).
// Produces a 2*WIDTH-bit product split into hi/lo; s=0 unsigned, s=1 signed.
// Sequence: IDLE -> CALC (WIDTH cycles) -> FIX (sign correction) -> DONE.
// Optional macro MULT_SEQ_OV_EN: registers an overflow flag (product does not
// fit in lo). Without it, ov is tied to 0 and no compare logic exists.
//
// Handshake: a request is taken on any rising edge where start=1 and busy=0
// (IDLE or DONE); operands and s are captured on that edge only. While busy=1,
// start is ignored. done is a one-cycle pulse marking hi/lo (and ov) valid;
// they then hold until the next accepted start.
module mult_seq_cla #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             s,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             ov
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [WIDTH-1:0]   ONE_W  = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [2*WIDTH-1:0] ONE_2W = {{(2*WIDTH-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_t;

    // state_q is the observable FSM state for checkers
    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q;
    logic            neg_q;
    logic [WIDTH-1:0] mcand_q;
    logic [WIDTH-1:0] hi_q, lo_q;

    logic             accept;
    logic             cnt_last;
    logic [WIDTH-1:0] mag1, mag2;
    logic [WIDTH:0]   calc_sum;
    logic [2*WIDTH-1:0] fix_prod;

    assign cnt_last = (cnt_q == CW'(WIDTH - 1));
    assign hi       = hi_q;
    assign lo       = lo_q;

    // Next-state and status outputs; DONE accepts a new start like IDLE
    always_comb begin
        state_d = state_q;
        busy    = 1'b0;
        done    = 1'b0;
        accept  = 1'b0;
        case (state_q)
            IDLE: begin
                accept = start;
                if (start) state_d = CALC;
            end
            CALC: begin
                busy = 1'b1;
                if (cnt_last) state_d = FIX;
            end
            FIX: begin
                busy    = 1'b1;
                state_d = DONE;
            end
            DONE: begin
                done    = 1'b1;
                accept  = start;
                state_d = start ? CALC : IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Operand magnitudes, one add step, and the sign-corrected final product
    always_comb begin
        mag1     = (s && in1[WIDTH-1]) ? (~in1 + ONE_W) : in1;
        mag2     = (s && in2[WIDTH-1]) ? (~in2 + ONE_W) : in2;
        calc_sum = {1'b0, hi_q} + {1'b0, (lo_q[0] ? mcand_q : {WIDTH{1'b0}})};
        fix_prod = neg_q ? (~{hi_q, lo_q} + ONE_2W) : {hi_q, lo_q};
    end

    // Datapath: load on accept, shift-add in CALC, sign fix in FIX
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q   <= '0;
            neg_q   <= 1'b0;
            mcand_q <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else if (accept) begin
            cnt_q   <= '0;
            neg_q   <= s & (in1[WIDTH-1] ^ in2[WIDTH-1]);
            mcand_q <= mag1;
            hi_q    <= '0;
            lo_q    <= mag2;
        end else if (state_q == CALC) begin
            cnt_q         <= cnt_q + 1'b1;
            {hi_q, lo_q}  <= {calc_sum, lo_q[WIDTH-1:1]};
        end else if (state_q == FIX) begin
            {hi_q, lo_q}  <= fix_prod;
        end
    end

`ifdef MULT_SEQ_OV_EN
    logic s_q;
    logic ov_q;
    logic ov_calc;

    // Overflow: high half is not just the sign/zero extension of lo
    always_comb begin
        if (s_q) ov_calc = (fix_prod[2*WIDTH-1:WIDTH] != {WIDTH{fix_prod[WIDTH-1]}});
        else     ov_calc = (fix_prod[2*WIDTH-1:WIDTH] != {WIDTH{1'b0}});
    end

    // Overflow flag registered alongside the final product
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s_q  <= 1'b0;
            ov_q <= 1'b0;
        end else if (accept) begin
            s_q  <= s;
            ov_q <= 1'b0;
        end else if (state_q == FIX) begin
            ov_q <= ov_calc;
        end
    end

    assign ov = ov_q;
`else
    assign ov = 1'b0;
`endif

endmodule

// File: tb/tb_mult_seq_cla.sv
// Directed testbench for mult_seq_cla: hand-computed products, latency,
// busy/done handshake, ignored restart, async reset abort, back-to-back ops.
module tb_mult_seq_cla;

    localparam int W = 32;
`ifdef MULT_SEQ_OV_EN
    localparam logic OV_ON = 1'b1;
`else
    localparam logic OV_ON = 1'b0;
`endif

    logic         clk;
    logic         rst_n;
    logic         start;
    logic         s;
    logic [W-1:0] in1, in2;
    logic         busy, done, ov;
    logic [W-1:0] hi, lo;

    int n_assert = 0;
    int n_fail   = 0;
    int lat, busy_cyc;

    mult_seq_cla #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .s     (s),
        .in1   (in1),
        .in2   (in2),
        .busy  (busy),
        .done  (done),
        .hi    (hi),
        .lo    (lo),
        .ov    (ov)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Count edges (already lat edges in) until done is seen, bounded
    task automatic wait_done(inout int l, inout int b);
        for (int i = 0; i < 100; i++) begin
            if (done === 1'b1) return;
            @(posedge clk); #1;
            l++;
            if (busy === 1'b1) b++;
        end
    endtask

    // Start one operation with a single-cycle start pulse and wait for done
    task automatic do_op(input logic sm, input logic [W-1:0] a, input logic [W-1:0] b_op);
        @(negedge clk);
        s = sm; in1 = a; in2 = b_op; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        in1 = $urandom; in2 = $urandom;
        lat = 1;
        busy_cyc = (busy === 1'b1) ? 1 : 0;
        wait_done(lat, busy_cyc);
    endtask

    task automatic check_result(input string tag, input logic [W-1:0] e_hi, input logic [W-1:0] e_lo, input logic e_ov);
        check({tag, "_lat"}, 64'(lat), 64'd34);
        check({tag, "_done"}, 64'(done), 64'd1);
        check({tag, "_hi"}, 64'(hi), 64'(e_hi));
        check({tag, "_lo"}, 64'(lo), 64'(e_lo));
        check({tag, "_ov"}, 64'(ov), 64'(e_ov));
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; s = 1'b0; in1 = '0; in2 = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_hilo", {hi, lo}, 64'd0);
        check("rst_ov", 64'(ov), 64'd0);
        @(negedge clk); rst_n = 1'b1;

        // Unsigned 3*10, with busy length and one-cycle done
        do_op(1'b0, 32'd3, 32'd10);
        check("u3x10_busy", 64'(busy_cyc), 64'd33);
        check_result("u3x10", 32'h0, 32'h1E, 1'b0);
        @(posedge clk); #1;
        check("u3x10_done_pulse", 64'(done), 64'd0);
        check("u3x10_hold", {hi, lo}, 64'h1E);

        // Signed -1*5 and -7*0
        do_op(1'b1, 32'hFFFF_FFFF, 32'd5);
        check_result("sm1x5", 32'hFFFF_FFFF, 32'hFFFF_FFFB, 1'b0);
        do_op(1'b1, 32'hFFFF_FFF9, 32'd0);
        check_result("sm7x0", 32'h0, 32'h0, 1'b0);

        // Signed -3*-4 = 12
        do_op(1'b1, 32'hFFFF_FFFD, 32'hFFFF_FFFC);
        check_result("sm3xm4", 32'h0, 32'd12, 1'b0);

        // Unsigned max and signed min
        do_op(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        check_result("umax", 32'hFFFF_FFFE, 32'h0000_0001, OV_ON);
        do_op(1'b1, 32'h8000_0000, 32'h8000_0000);
        check_result("smin", 32'h4000_0000, 32'h0, OV_ON);

        // Signed 0x80000000 * 1 fits (no overflow)
        do_op(1'b1, 32'h8000_0000, 32'd1);
        check_result("smin_x1", 32'hFFFF_FFFF, 32'h8000_0000, 1'b0);

        // Restart while busy is ignored: 100*200 = 20000
        @(negedge clk);
        s = 1'b0; in1 = 32'd100; in2 = 32'd200; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        lat = 1; busy_cyc = 1;
        repeat (4) begin @(posedge clk); #1; lat++; end
        @(negedge clk);
        in1 = 32'd9; in2 = 32'd9; start = 1'b1;
        @(posedge clk); #1;
        lat++;
        start = 1'b0;
        check("ign_busy", 64'(busy), 64'd1);
        wait_done(lat, busy_cyc);
        check_result("ignore", 32'h0, 32'd20000, 1'b0);

        // Reset mid-operation clears immediately, then 6*7
        @(negedge clk);
        s = 1'b0; in1 = 32'd1000; in2 = 32'd1000; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (9) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_busy", 64'(busy), 64'd0);
        check("arst_hilo", {hi, lo}, 64'd0);
        check("arst_done", 64'(done), 64'd0);
        @(negedge clk); rst_n = 1'b1;
        do_op(1'b0, 32'd6, 32'd7);
        check_result("post_rst", 32'h0, 32'd42, 1'b0);

        // Back-to-back: start held high through DONE
        @(negedge clk);
        s = 1'b0; in1 = 32'd5; in2 = 32'd5; start = 1'b1;
        @(posedge clk); #1;
        lat = 1; busy_cyc = 1;
        wait_done(lat, busy_cyc);
        check_result("b2b_first", 32'h0, 32'd25, 1'b0);
        in1 = 32'd11; in2 = 32'd13;
        @(posedge clk); #1;
        lat = 1;
        check("b2b_accept_busy", 64'(busy), 64'd1);
        wait_done(lat, busy_cyc);
        start = 1'b0;
        check_result("b2b_second", 32'h0, 32'd143, 1'b0);
        @(posedge clk); #1;
        check("b2b_idle_busy", 64'(busy), 64'd0);
        check("b2b_idle_done", 64'(done), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
